outer_ebi_ctrl: RTL and testbench

OUTER_EBI_CTRL -- requirements
Module: outer_ebi_ctrl

---
 rtl/outer_ebi_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_outer_ebi_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/outer_ebi_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// outer_ebi_ctrl : external bus sequencer -- receive decode, send
// arbitration and transfer watchdog.  Rev 1.0
// ------------------------------------------------------------------
module outer_ebi_ctrl #(
  parameter logic [7:0] WDOG_MAX = 8'd255
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       trx_rcv_start,
  input  logic       trx_rcv_done,
  input  logic       trx_send_done,
  input  logic [3:0] hdr_opcode,
  output logic [3:0] trx_opcode,
  output logic       trx_counter_reload,
  output logic       trx_counter_ena,
  output logic       trx_rd_rcv,
  output logic       trx_send_mode,
  input  logic       ack_req,
  input  logic       rdr_req,
  input  logic       snp_req,
  output logic       ack_gnt,
  output logic       rdr_gnt,
  output logic       snp_gnt,
  output logic       send_done,
  output logic       rcv_valid,
  input  logic       rcv_ready,
  output logic [2:0] rcv_type,
  output logic       err_pulse
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RCV_HDR   = 3'd1,
    S_RCV_DATA  = 3'd2,
    S_RCV_HOLD  = 3'd3,
    S_SEND_LOAD = 3'd4,
    S_SEND      = 3'd5,
    S_SEND_END  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_ACK  = 2'd1,
    G_RDR  = 2'd2,
    G_SNP  = 2'd3
  } gnt_t;

  state_t     state_q, state_d;
  gnt_t       gnt_q, gnt_d;
  logic [7:0] wdog_q, wdog_d;
  logic [2:0] type_q, type_d;
  logic       armed_q;
  logic       wdog_exp;

  logic [3:0] opcode_q, opcode_d;
  logic       reload_q, reload_d;
  logic       ena_q, ena_d;
  logic       rd_q, rd_d;
  logic       mode_q, mode_d;
  logic       ack_gnt_q, ack_gnt_d;
  logic       rdr_gnt_q, rdr_gnt_d;
  logic       snp_gnt_q, snp_gnt_d;
  logic       sdone_q, sdone_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    type_d   = type_q;
    err_d    = 1'b0;
    wdog_exp = (wdog_q == WDOG_MAX - 8'd1);
    case (state_q)
      // armed_q masks the first cycle after reset release
      S_IDLE: if (armed_q) begin
        if (trx_rcv_start) begin
          state_d = S_RCV_HDR;
        end else if (ack_req) begin
          state_d = S_SEND_LOAD;
          gnt_d   = G_ACK;
        end else if (rdr_req) begin
          state_d = S_SEND_LOAD;
          gnt_d   = G_RDR;
        end else if (snp_req) begin
          state_d = S_SEND_LOAD;
          gnt_d   = G_SNP;
        end
      end
      S_RCV_HDR: begin
        if (hdr_opcode <= 4'd4) begin
          type_d  = hdr_opcode[2:0];
          state_d = S_RCV_DATA;
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RCV_DATA: begin
        if (trx_rcv_done) begin
          state_d = S_RCV_HOLD;
        end else if (wdog_exp) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RCV_HOLD: if (rcv_ready) state_d = S_IDLE;
      S_SEND_LOAD: state_d = S_SEND;
      S_SEND: begin
        if (trx_send_done) begin
          state_d = S_SEND_END;
        end else if (wdog_exp) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_SEND_END: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) gnt_d = G_NONE;

    // Counter restarts on every entry into a timed state.
    if ((state_q == S_RCV_DATA || state_q == S_SEND) && state_d == state_q)
      wdog_d = wdog_q + 8'd1;
    else
      wdog_d = 8'd0;

    // Outputs are registered versions of the next-state decode.
    reload_d  = (state_d == S_RCV_HDR) || (state_d == S_SEND_LOAD);
    ena_d     = (state_d == S_RCV_DATA) || (state_d == S_SEND);
    rd_d      = (state_d == S_RCV_DATA);
    mode_d    = (state_d == S_SEND);
    ack_gnt_d = (state_d == S_SEND_LOAD) && (gnt_d == G_ACK);
    rdr_gnt_d = (state_d == S_SEND_LOAD) && (gnt_d == G_RDR);
    snp_gnt_d = (state_d == S_SEND_LOAD) && (gnt_d == G_SNP);
    sdone_d   = (state_d == S_SEND_END);
    valid_d   = (state_d == S_RCV_HOLD);
    opcode_d  = 4'hF;
    if (state_d == S_SEND_LOAD || state_d == S_SEND || state_d == S_SEND_END) begin
      case (gnt_d)
        G_RDR:   opcode_d = 4'h7;
        G_SNP:   opcode_d = 4'h6;
        default: opcode_d = 4'hF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      gnt_q     <= G_NONE;
      wdog_q    <= 8'd0;
      type_q    <= 3'd0;
      armed_q   <= 1'b0;
      opcode_q  <= 4'hF;
      reload_q  <= 1'b0;
      ena_q     <= 1'b0;
      rd_q      <= 1'b0;
      mode_q    <= 1'b0;
      ack_gnt_q <= 1'b0;
      rdr_gnt_q <= 1'b0;
      snp_gnt_q <= 1'b0;
      sdone_q   <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      wdog_q    <= wdog_d;
      type_q    <= type_d;
      armed_q   <= 1'b1;
      opcode_q  <= opcode_d;
      reload_q  <= reload_d;
      ena_q     <= ena_d;
      rd_q      <= rd_d;
      mode_q    <= mode_d;
      ack_gnt_q <= ack_gnt_d;
      rdr_gnt_q <= rdr_gnt_d;
      snp_gnt_q <= snp_gnt_d;
      sdone_q   <= sdone_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign trx_opcode         = opcode_q;
  assign trx_counter_reload = reload_q;
  assign trx_counter_ena    = ena_q;
  assign trx_rd_rcv         = rd_q;
  assign trx_send_mode      = mode_q;
  assign ack_gnt            = ack_gnt_q;
  assign rdr_gnt            = rdr_gnt_q;
  assign snp_gnt            = snp_gnt_q;
  assign send_done          = sdone_q;
  assign rcv_valid          = valid_q;
  assign rcv_type           = type_q;
  assign err_pulse          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_outer_ebi_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// tb_outer_ebi_ctrl : directed vector bench for outer_ebi_ctrl.
// Rev 1.0
// ------------------------------------------------------------------
module tb_outer_ebi_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       trx_rcv_start = 1'b0, trx_rcv_done = 1'b0, trx_send_done = 1'b0;
  logic [3:0] hdr_opcode = 4'h0;
  logic       ack_req = 1'b0, rdr_req = 1'b0, snp_req = 1'b0, rcv_ready = 1'b0;
  logic [3:0] trx_opcode;
  logic       trx_counter_reload, trx_counter_ena, trx_rd_rcv, trx_send_mode;
  logic       ack_gnt, rdr_gnt, snp_gnt, send_done, rcv_valid, err_pulse;
  logic [2:0] rcv_type;

  always #5 clk = ~clk;

  outer_ebi_ctrl #(.WDOG_MAX(8'd255)) dut (
    .clk(clk), .rstn(rstn),
    .trx_rcv_start(trx_rcv_start), .trx_rcv_done(trx_rcv_done),
    .trx_send_done(trx_send_done), .hdr_opcode(hdr_opcode),
    .trx_opcode(trx_opcode), .trx_counter_reload(trx_counter_reload),
    .trx_counter_ena(trx_counter_ena), .trx_rd_rcv(trx_rd_rcv),
    .trx_send_mode(trx_send_mode),
    .ack_req(ack_req), .rdr_req(rdr_req), .snp_req(snp_req),
    .ack_gnt(ack_gnt), .rdr_gnt(rdr_gnt), .snp_gnt(snp_gnt),
    .send_done(send_done), .rcv_valid(rcv_valid), .rcv_ready(rcv_ready),
    .rcv_type(rcv_type), .err_pulse(err_pulse)
  );

  // Observed output word: {opcode, reload, ena, rd, mode, gnts, done, valid, type, err}
  logic [16:0] obs;
  assign obs = {trx_opcode, trx_counter_reload, trx_counter_ena, trx_rd_rcv,
                trx_send_mode, ack_gnt, rdr_gnt, snp_gnt, send_done,
                rcv_valid, rcv_type, err_pulse};

  localparam logic [16:0] RL = 17'h01000, EN = 17'h00800, RD = 17'h00400,
                          SM = 17'h00200, AG = 17'h00100, RG = 17'h00080,
                          SG = 17'h00040, SD = 17'h00020, VL = 17'h00010,
                          ER = 17'h00001, NO = 17'h00000;
  localparam logic [10:0] IS = 11'h400, IRD = 11'h200, ISD = 11'h100,
                          IA = 11'h008, IR = 11'h004, IN = 11'h002,
                          IY = 11'h001, I0 = 11'h000;

  typedef struct {
    logic [10:0] vin;
    logic [16:0] vexp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;
  int   cnt;

  function automatic logic [16:0] ex(input logic [3:0] op, input logic [16:0] f,
                                     input logic [2:0] t);
    return {op, 13'b0} | f | {13'b0, t, 1'b0};
  endfunction

  function automatic logic [10:0] vi(input logic [10:0] f, input logic [3:0] h);
    return f | {3'b0, h, 4'b0};
  endfunction

  function automatic void add(input logic [10:0] v, input logic [16:0] e);
    vec_t r;
    r.vin  = v;
    r.vexp = e;
    vecs.push_back(r);
  endfunction

  task automatic apply(input logic [10:0] v);
    {trx_rcv_start, trx_rcv_done, trx_send_done, hdr_opcode,
     ack_req, rdr_req, snp_req, rcv_ready} = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // Read receive, start ignored mid-receive
    add(vi(IS, 0),       ex(4'hF, RL, 0));
    add(vi(I0, 0),       ex(4'hF, EN | RD, 0));
    add(vi(IS, 0),       ex(4'hF, EN | RD, 0));
    add(vi(I0, 0),       ex(4'hF, EN | RD, 0));
    add(vi(IRD, 0),      ex(4'hF, VL, 0));
    add(vi(I0, 0),       ex(4'hF, VL, 0));
    add(vi(IY, 0),       ex(4'hF, NO, 0));
    // Receive beats a simultaneous rdr request; rdr dropped after grant
    add(vi(IS | IR, 0),  ex(4'hF, RL, 0));
    add(vi(IR, 1),       ex(4'hF, EN | RD, 1));
    add(vi(IRD | IR, 0), ex(4'hF, VL, 1));
    add(vi(IY | IR, 0),  ex(4'hF, NO, 1));
    add(vi(IR, 0),       ex(4'h7, RL | RG, 1));
    add(vi(I0, 0),       ex(4'h7, SM | EN, 1));
    add(vi(ISD, 0),      ex(4'h7, SD, 1));
    add(vi(I0, 0),       ex(4'hF, NO, 1));
    // Three-way arbitration ack > rdr > snp with turnaround gaps
    add(vi(IA | IR | IN, 0),       ex(4'hF, RL | AG, 1));
    add(vi(IA | IR | IN, 0),       ex(4'hF, SM | EN, 1));
    add(vi(IA | IR | IN | ISD, 0), ex(4'hF, SD, 1));
    add(vi(IR | IN, 0),  ex(4'hF, NO, 1));
    add(vi(IR | IN, 0),  ex(4'h7, RL | RG, 1));
    add(vi(IR | IN, 0),  ex(4'h7, SM | EN, 1));
    add(vi(IN | ISD, 0), ex(4'h7, SD, 1));
    add(vi(IN, 0),       ex(4'hF, NO, 1));
    add(vi(IN, 0),       ex(4'h6, RL | SG, 1));
    add(vi(I0, 0),       ex(4'h6, SM | EN, 1));
    add(vi(ISD, 0),      ex(4'h6, SD, 1));
    add(vi(I0, 0),       ex(4'hF, NO, 1));
    // Bad opcode 9, then boundary opcodes 4 (good) and 5 (bad)
    add(vi(IS, 0),       ex(4'hF, RL, 1));
    add(vi(I0, 9),       ex(4'hF, ER, 1));
    add(vi(I0, 0),       ex(4'hF, NO, 1));
    add(vi(IS, 0),       ex(4'hF, RL, 1));
    add(vi(I0, 4),       ex(4'hF, EN | RD, 4));
    add(vi(IRD | IY, 0), ex(4'hF, VL, 4));
    add(vi(IY, 0),       ex(4'hF, NO, 4));
    add(vi(IS, 0),       ex(4'hF, RL, 4));
    add(vi(I0, 5),       ex(4'hF, ER, 4));
    add(vi(I0, 0),       ex(4'hF, NO, 4));

    apply(I0);
    #12;
    check("reset_state", obs, ex(4'hF, NO, 0));

    // First edge after release must ignore a start
    apply(IS);
    @(negedge clk) rstn = 1'b1;
    tick();
    apply(I0);
    check("ignore_first_edge", obs, ex(4'hF, NO, 0));
    tick();
    check("ignore_first_idle", obs, ex(4'hF, NO, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].vin);
      tick();
      check($sformatf("vec%0d", i), obs, vecs[i].vexp);
    end

    // Watchdog abort from SEND
    apply(IA);
    tick();
    check("wd_load", obs, ex(4'hF, RL | AG, 4));
    apply(I0);
    tick();
    cnt = 0;
    while (trx_send_mode === 1'b1 && cnt < 400) begin
      cnt++;
      tick();
    end
    check("wd_send_cycles", 17'(cnt), 17'd255);
    check("wd_abort", obs, ex(4'hF, ER, 4));
    tick();
    check("wd_after", obs, ex(4'hF, NO, 4));

    // send_done wins over expiry in the same cycle
    apply(IA);
    tick();
    apply(I0);
    tick();
    repeat (254) tick();
    check("wd_last_cycle", obs, ex(4'hF, SM | EN, 4));
    apply(ISD);
    tick();
    check("done_beats_wd", obs, ex(4'hF, SD, 4));
    apply(I0);
    tick();
    check("done_beats_wd_idle", obs, ex(4'hF, NO, 4));

    // Reset in the middle of a send
    apply(IR);
    tick();
    apply(I0);
    tick();
    check("rst_pre_send", obs, ex(4'h7, SM | EN, 4));
    rstn = 1'b0;
    #1;
    check("rst_async", obs, ex(4'hF, NO, 0));
    apply(ISD | IS);
    #20;
    @(negedge clk) rstn = 1'b1;
    tick();
    check("rst_release_edge1", obs, ex(4'hF, NO, 0));
    tick();
    check("rst_release_edge2", obs, ex(4'hF, RL, 0));
    apply(vi(I0, 9));
    tick();
    check("rst_release_err", obs, ex(4'hF, ER, 0));
    apply(I0);
    tick();
    check("rst_release_idle", obs, ex(4'hF, NO, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
